// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : op-codes, FSM state encoding and helpers shared by the
//           controller and the ALU.                              Rev 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [2:0] c_OP_ADD    = 3'b000;
    localparam logic [2:0] c_OP_SUB    = 3'b001;
    localparam logic [2:0] c_OP_NAND   = 3'b010;
    localparam logic [2:0] c_OP_PASS_A = 3'b011;
    localparam logic [2:0] c_OP_PASS_B = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ_A = 3'd1,
        ST_READ_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= c_OP_PASS_B);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_controller_if.sv
// ============================================================================
// alu_controller_if : command, register-file, ALU and status signals of the
//                     ALU controller. master = environment, slave = controller.
// Rev 1.0
// ============================================================================
`default_nettype none

interface alu_controller_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [REG_AW-1:0] cmd_rd;
    logic [REG_AW-1:0] cmd_rs1;
    logic [REG_AW-1:0] cmd_rs2;
    logic [REG_AW-1:0] rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] alu_op_a;
    logic [DATA_W-1:0] alu_op_b;
    logic [2:0]        alu_op_select;
    logic [DATA_W-1:0] alu_result;
    logic              busy;
    logic              done;
    logic              illegal_op;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, rf_rdata, alu_result,
        input  cmd_ready, rf_raddr, rf_we, rf_waddr, rf_wdata,
               alu_op_a, alu_op_b, alu_op_select, busy, done, illegal_op
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, rf_rdata, alu_result,
        output cmd_ready, rf_raddr, rf_we, rf_waddr, rf_wdata,
               alu_op_a, alu_op_b, alu_op_select, busy, done, illegal_op
    );
endinterface

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// alu : combinational ALU driven by alu_controller; illegal op-codes give 0.
// Rev 1.0
// ============================================================================
`default_nettype none

module alu
    import alu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  wire logic [DATA_W-1:0] i_a,
    input  wire logic [DATA_W-1:0] i_b,
    input  wire logic [2:0]        i_op,
    output logic      [DATA_W-1:0] o_result
);

    always_comb begin
        o_result = '0;
        case (i_op)
            c_OP_ADD:    o_result = i_a + i_b;
            c_OP_SUB:    o_result = i_a - i_b;
            c_OP_NAND:   o_result = ~(i_a & i_b);
            c_OP_PASS_A: o_result = i_a;
            c_OP_PASS_B: o_result = i_b;
            default:     o_result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_controller.sv
// ============================================================================
// alu_controller : sequences read-A, read-B, execute and write-back of one
//                  register-file ALU command at a time.          Rev 1.0
// ============================================================================
`default_nettype none

module alu_controller
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    alu_controller_if.slave  bus
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_live;
    logic [2:0]        r_op;
    logic [REG_AW-1:0] r_rd;
    logic [REG_AW-1:0] r_rs1;
    logic [REG_AW-1:0] r_rs2;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic              r_illegal;

    logic              w_ready;
    logic              w_accept;
    logic [REG_AW-1:0] w_raddr;
    logic              w_rf_we;
    logic              w_done;

    // r_live holds cmd_ready low until the first edge that samples rst_n high.
    assign w_ready  = rst_n && r_live && (r_state == ST_IDLE);
    assign w_accept = bus.cmd_valid && w_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_raddr     = r_rs1;
        w_rf_we     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && is_legal_op(bus.cmd_op)) begin
                    w_state_nxt = ST_READ_A;
                end
            end
            ST_READ_A: w_state_nxt = ST_READ_B;
            ST_READ_B: begin
                w_raddr     = r_rs2;
                w_state_nxt = ST_EXEC;
            end
            ST_EXEC:   w_state_nxt = ST_WB;
            ST_WB: begin
                w_rf_we     = rst_n;
                w_done      = rst_n;
                w_state_nxt = ST_IDLE;
            end
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Read data lags the address by one cycle, so each operand lands one state late.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op      <= '0;
            r_rd      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_accept && !is_legal_op(bus.cmd_op);
            if (w_accept) begin
                r_op  <= bus.cmd_op;
                r_rd  <= bus.cmd_rd;
                r_rs1 <= bus.cmd_rs1;
                r_rs2 <= bus.cmd_rs2;
            end
            if (r_state == ST_READ_B) begin
                r_op_a <= bus.rf_rdata;
            end
            if (r_state == ST_EXEC) begin
                r_op_b <= bus.rf_rdata;
            end
        end
    end

    assign bus.cmd_ready     = w_ready;
    assign bus.busy          = rst_n && (r_state != ST_IDLE);
    assign bus.rf_raddr      = w_raddr;
    assign bus.rf_we         = w_rf_we;
    assign bus.rf_waddr      = r_rd;
    assign bus.rf_wdata      = bus.alu_result;
    assign bus.alu_op_a      = r_op_a;
    assign bus.alu_op_b      = r_op_b;
    assign bus.alu_op_select = r_op;
    assign bus.done          = w_done;
    assign bus.illegal_op    = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_controller.sv
// ============================================================================
// tb_alu_controller : directed and random commands against a register-file
//                     model and an arithmetic reference.         Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_controller;

    localparam int DW = 16;
    localparam int AW = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_controller_if #(.DATA_W(DW), .REG_AW(AW)) bus();

    alu_controller #(.DATA_W(DW), .REG_AW(AW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    alu #(.DATA_W(DW)) u_alu (
        .i_a      (bus.alu_op_a),
        .i_b      (bus.alu_op_b),
        .i_op     (bus.alu_op_select),
        .o_result (bus.alu_result)
    );

    logic [DW-1:0] rf  [8];
    logic [DW-1:0] mdl [8];
    logic          pre_we   = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    int cyc = 0, wr_cnt = 0, done_cnt = 0;
    int acc_q[$];
    int tests = 0, fails = 0;

    // Register file: one-cycle read latency, plus a bench-side preload port.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        bus.rf_rdata <= rf[bus.rf_raddr];
        if (pre_we) rf[pre_addr] <= pre_data;
        else if (bus.rf_we) rf[bus.rf_waddr] <= bus.rf_wdata;
        if (bus.rf_we) wr_cnt <= wr_cnt + 1;
        if (bus.done) done_cnt <= done_cnt + 1;
        if (bus.cmd_valid && bus.cmd_ready) acc_q.push_back(cyc);
    end

    function automatic logic [DW-1:0] ref_alu(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return ~(a & b);
            3'd3:    return a;
            3'd4:    return b;
            default: return '0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        step();
        pre_we = 1'b0;
        mdl[a] = d;
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
        int w0, d0;
        logic [DW-1:0] exp;
        exp = ref_alu(op, mdl[rs1], mdl[rs2]);
        w0 = wr_cnt; d0 = done_cnt;
        chk("ready_before", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2;
        step();
        bus.cmd_valid = 1'b0;
        if (op > 3'd4) begin
            chk("illegal_pulse", bus.illegal_op, 1);
            chk("illegal_ready", bus.cmd_ready, 1);
            chk("illegal_no_we", bus.rf_we, 0);
            step();
            chk("illegal_clear", bus.illegal_op, 0);
            chk("illegal_no_write", wr_cnt - w0, 0);
            chk("illegal_no_done", done_cnt - d0, 0);
        end else begin
            chk("rda_raddr", bus.rf_raddr, rs1);
            chk("rda_busy", bus.busy, 1);
            chk("rda_ready", bus.cmd_ready, 0);
            step();
            chk("rdb_raddr", bus.rf_raddr, rs2);
            chk("rdb_we", bus.rf_we, 0);
            step();
            chk("exec_opa", bus.alu_op_a, mdl[rs1]);
            chk("exec_done", bus.done, 0);
            step();
            chk("wb_opb", bus.alu_op_b, mdl[rs2]);
            chk("wb_we", bus.rf_we, 1);
            chk("wb_waddr", bus.rf_waddr, rd);
            chk("wb_wdata", bus.rf_wdata, exp);
            chk("wb_done", bus.done, 1);
            step();
            chk("post_ready", bus.cmd_ready, 1);
            chk("post_we", bus.rf_we, 0);
            chk("post_done", bus.done, 0);
            chk("one_write", wr_cnt - w0, 1);
            chk("one_done", done_cnt - d0, 1);
            chk("rf_value", rf[rd], exp);
            mdl[rd] = exp;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] e5, e6;
        int ready_low, w0;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_rd = '0; bus.cmd_rs1 = '0; bus.cmd_rs2 = '0;
        rst_n = 1'b0;
        step(); step();
        chk("rst_ready", bus.cmd_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_we", bus.rf_we, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_illegal", bus.illegal_op, 0);
        chk("rst_opa", bus.alu_op_a, 0);
        chk("rst_opb", bus.alu_op_b, 0);
        chk("rst_sel", bus.alu_op_select, 0);
        for (int i = 0; i < 8; i++) preload(AW'(i), DW'($urandom));
        rst_n = 1'b1;
        chk("release_ready_wait", bus.cmd_ready, 0);
        step();
        chk("release_ready", bus.cmd_ready, 1);
        chk("release_busy", bus.busy, 0);

        preload(3'd1, 16'h0005); preload(3'd2, 16'h0003);
        run_cmd(3'd0, 3'd3, 3'd1, 3'd2);
        chk("add_r3", rf[3], 16'h0008);

        preload(3'd1, 16'h0000); preload(3'd2, 16'h0001);
        run_cmd(3'd1, 3'd4, 3'd1, 3'd2);
        chk("sub_wrap_r4", rf[4], 16'hFFFF);

        preload(3'd1, 16'hF0F0); preload(3'd2, 16'hFF00);
        run_cmd(3'd2, 3'd1, 3'd1, 3'd2);
        chk("nand_alias_r1", rf[1], 16'h0FFF);

        run_cmd(3'b110, 3'd5, 3'd1, 3'd2);

        // Back-to-back with cmd_valid held high.
        e5 = mdl[1];
        e6 = mdl[0];
        acc_q.delete();
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'd3; bus.cmd_rd = 3'd5; bus.cmd_rs1 = 3'd1; bus.cmd_rs2 = 3'd2;
        step();
        bus.cmd_op = 3'd4; bus.cmd_rd = 3'd6; bus.cmd_rs1 = 3'd3; bus.cmd_rs2 = 3'd0;
        ready_low = 0;
        for (int i = 0; i < 10 && acc_q.size() < 2; i++) begin
            if (!bus.cmd_ready) ready_low++;
            step();
        end
        bus.cmd_valid = 1'b0;
        chk("b2b_accepts", acc_q.size(), 2);
        if (acc_q.size() == 2) chk("b2b_spacing", acc_q[1] - acc_q[0], 5);
        chk("b2b_ready_low", ready_low, 4);
        for (int i = 0; i < 4; i++) step();
        chk("b2b_r5", rf[5], e5);
        chk("b2b_r6", rf[6], e6);
        mdl[5] = e5; mdl[6] = e6;

        // Reset during EXEC of an ADD aborts the write.
        w0 = wr_cnt;
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'd0; bus.cmd_rd = 3'd7; bus.cmd_rs1 = 3'd1; bus.cmd_rs2 = 3'd2;
        step();
        bus.cmd_valid = 1'b0;
        step(); step();
        rst_n = 1'b0;
        step();
        chk("abort_we", bus.rf_we, 0);
        chk("abort_ready", bus.cmd_ready, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_opa", bus.alu_op_a, 0);
        rst_n = 1'b1;
        step();
        chk("abort_release_ready", bus.cmd_ready, 1);
        step(); step(); step();
        chk("abort_no_write", wr_cnt - w0, 0);
        chk("abort_r7", rf[7], mdl[7]);

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 2) == 0) preload(AW'($urandom_range(0, 7)), DW'($urandom));
            run_cmd(3'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                    AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end
        for (int i = 0; i < 8; i++) chk("final_rf", rf[i], mdl[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
